bbq_grill_controller: RTL and testbench
=======================================

// Module: bbq_grill_controller
// PURPOSE
//  Multi-slot doneness controller for the Barbeque Hero grill. Tracks NUM_SLOTS steaks independently.
//  Each steak advances through 8 doneness levels on a cooking timer or on a flip release.
//  Drives per-slot fat/muscle colours to the renderer. Sits between the input debouncers and the VGA draw datapath.
// PARAMETERS
//  NUM_SLOTS        4    number of independent steak slots (1..8)
//  TICKS_PER_LEVEL  3    cook ticks needed to advance one level when unattended (1..255)
//  COLOUR_W         9    colour width in bits (RGB 3:3:3)
// PORTS
//  clk            in   1                    system clock
//  resetn         in   1                    synchronous, active-low reset
//  tick           in   1                    1-cycle cook-timer pulse, shared by all slots
//  flip           in   NUM_SLOTS            level-sensitive per-slot flip button, 1 = held
//  colour_fat     out  NUM_SLOTS*COLOUR_W   slot i at [i*COLOUR_W +: COLOUR_W]
//  colour_muscle  out  NUM_SLOTS*COLOUR_W   same packing as colour_fat
//  level          out  NUM_SLOTS*3          current doneness level per slot, slot i at [i*3 +: 3]
//  burnt_alarm    out  NUM_SLOTS            sticky per-slot burn flag; present only with BBQ_BURN_ALARM_EN
//  alarm_clr      in   1                    clears all burnt_alarm bits; present only with BBQ_BURN_ALARM_EN
// BEHAVIOUR
//  - Levels: 0 NONE, 1 RAW, 2 RARE, 3 MED_RARE, 4 MEDIUM, 5 MED_WELL, 6 WELL, 7 BURNT.
//  - Per-slot state: level[2:0], held (registered flip), cnt (count of ticks at the current level).
//  - Reset: all levels 0, held 0, cnt 0; all colour outputs 0; burnt_alarm 0.
//  - Release event: held==1 and flip==0 in a cycle. On the next edge, level advances by 1 (BURNT wraps to NONE) and cnt clears.
//  - Flip held (held==1 or flip==1): cooking is paused; tick is ignored and cnt holds.
//  - Timer: when level!=NONE, not paused, and tick==1:
//      cnt < TICKS_PER_LEVEL-1: cnt increments.
//      cnt == TICKS_PER_LEVEL-1: level advances and cnt clears.
//    BURNT times out to NONE (steak removed).
//  - NONE never advances on tick; only a release event places a steak (NONE->RAW).
//  - Release and tick in the same cycle: release wins, exactly one level of advance, cnt cleared.
//  - Slots are fully independent; simultaneous events on different slots all take effect in the same cycle.
//  - Colours are a combinational lookup on the registered level, so there is zero-cycle latency from level.
//    NONE yields 0/0. Each other level maps to distinct, strictly ordered fat/muscle constants; no level reuses another's colour.
//  - Reset asserted mid-cook: the whole state returns to reset values on that edge, regardless of flip or tick.
// CONFIGURATION
//  - BBQ_BURN_ALARM_EN defined:
//      burnt_alarm and alarm_clr ports exist.
//      burnt_alarm[i] sets on the edge where slot i enters BURNT through the timer; entry through a release does not set it.
//      The bit stays set until alarm_clr==1. alarm_clr takes priority when set and clear coincide.
//  - BBQ_BURN_ALARM_EN undefined: neither port nor any alarm logic exists; all other behaviour is identical.
// STRUCTURE
//  - bbq_pkg holds the level localparams (LVL_NONE..LVL_BURNT), the COLOUR_W default,
//    and the FAT_COLOUR_*/MUSCLE_COLOUR_* constants indexed by level.
//  - Sub-module bbq_steak_slot: one instance per slot via generate. It holds level/held/cnt and the colour lookup.
//    The top level only fans out tick/alarm_clr and packs the outputs.
// TESTING
//  - Reset, then flip[0] high 2 cycles, then low: level[0] goes 0->1 one cycle after release; other slots stay 0.
//  - TICKS_PER_LEVEL=3, slot at RAW, 6 ticks with no flip: RAW->RARE after tick 3, ->MED_RARE after tick 6.
//  - Slot at RARE with cnt=2, release and tick in the same cycle: level=MED_RARE, cnt=0 (single advance only).
//  - Flip held across 5 ticks at MEDIUM: level stays 4, cnt unchanged. After release, level=5.
//  - Timer drives WELL->BURNT: burnt_alarm[i]=1 (alarm build). Further ticks: BURNT->NONE, alarm still 1.
//    alarm_clr pulse -> alarm 0. A NONE slot then holds at NONE through 10 ticks.
//  - All 4 slots released in the same cycle from NONE: every level=1 and every colour equals the RAW constants.
//    Assert resetn=0 mid-cook: all outputs return to 0.

Source files
------------

// File: rtl/bbq_pkg.sv
// Shared definitions for the grill controller: doneness level encodings,
// default colour width and the per-level fat/muscle colour constants (RGB 3:3:3).
package bbq_pkg;

  localparam int COLOUR_W_DEFAULT = 9;

  localparam logic [2:0] LVL_NONE     = 3'd0;
  localparam logic [2:0] LVL_RAW      = 3'd1;
  localparam logic [2:0] LVL_RARE     = 3'd2;
  localparam logic [2:0] LVL_MED_RARE = 3'd3;
  localparam logic [2:0] LVL_MEDIUM   = 3'd4;
  localparam logic [2:0] LVL_MED_WELL = 3'd5;
  localparam logic [2:0] LVL_WELL     = 3'd6;
  localparam logic [2:0] LVL_BURNT    = 3'd7;

  // Fat gets steadily more saturated as the steak cooks.
  localparam logic [8:0] FAT_COLOUR_NONE     = 9'h000;
  localparam logic [8:0] FAT_COLOUR_RAW      = 9'h040;
  localparam logic [8:0] FAT_COLOUR_RARE     = 9'h080;
  localparam logic [8:0] FAT_COLOUR_MED_RARE = 9'h0C0;
  localparam logic [8:0] FAT_COLOUR_MEDIUM   = 9'h100;
  localparam logic [8:0] FAT_COLOUR_MED_WELL = 9'h140;
  localparam logic [8:0] FAT_COLOUR_WELL     = 9'h180;
  localparam logic [8:0] FAT_COLOUR_BURNT    = 9'h1C0;

  // Muscle starts bright red and darkens level by level.
  localparam logic [8:0] MUSCLE_COLOUR_NONE     = 9'h000;
  localparam logic [8:0] MUSCLE_COLOUR_RAW      = 9'h1E0;
  localparam logic [8:0] MUSCLE_COLOUR_RARE     = 9'h1A0;
  localparam logic [8:0] MUSCLE_COLOUR_MED_RARE = 9'h160;
  localparam logic [8:0] MUSCLE_COLOUR_MEDIUM   = 9'h120;
  localparam logic [8:0] MUSCLE_COLOUR_MED_WELL = 9'h0E0;
  localparam logic [8:0] MUSCLE_COLOUR_WELL     = 9'h0A0;
  localparam logic [8:0] MUSCLE_COLOUR_BURNT    = 9'h060;

  function automatic logic [8:0] fat_colour(input logic [2:0] lvl);
    case (lvl)
      LVL_RAW:      fat_colour = FAT_COLOUR_RAW;
      LVL_RARE:     fat_colour = FAT_COLOUR_RARE;
      LVL_MED_RARE: fat_colour = FAT_COLOUR_MED_RARE;
      LVL_MEDIUM:   fat_colour = FAT_COLOUR_MEDIUM;
      LVL_MED_WELL: fat_colour = FAT_COLOUR_MED_WELL;
      LVL_WELL:     fat_colour = FAT_COLOUR_WELL;
      LVL_BURNT:    fat_colour = FAT_COLOUR_BURNT;
      default:      fat_colour = FAT_COLOUR_NONE;
    endcase
  endfunction

  function automatic logic [8:0] muscle_colour(input logic [2:0] lvl);
    case (lvl)
      LVL_RAW:      muscle_colour = MUSCLE_COLOUR_RAW;
      LVL_RARE:     muscle_colour = MUSCLE_COLOUR_RARE;
      LVL_MED_RARE: muscle_colour = MUSCLE_COLOUR_MED_RARE;
      LVL_MEDIUM:   muscle_colour = MUSCLE_COLOUR_MEDIUM;
      LVL_MED_WELL: muscle_colour = MUSCLE_COLOUR_MED_WELL;
      LVL_WELL:     muscle_colour = MUSCLE_COLOUR_WELL;
      LVL_BURNT:    muscle_colour = MUSCLE_COLOUR_BURNT;
      default:      muscle_colour = MUSCLE_COLOUR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/bbq_grill_controller_if.sv
// Grill controller bus: cook tick, per-slot flip buttons and the packed
// level/colour outputs. Burn-alarm signals exist only with BBQ_BURN_ALARM_EN.
interface bbq_grill_controller_if #(
  parameter int NUM_SLOTS = 4,
  parameter int COLOUR_W  = 9
);
  logic                          tick;
  logic [NUM_SLOTS-1:0]          flip;
  logic [NUM_SLOTS*COLOUR_W-1:0] colour_fat;
  logic [NUM_SLOTS*COLOUR_W-1:0] colour_muscle;
  logic [NUM_SLOTS*3-1:0]        level;
`ifdef BBQ_BURN_ALARM_EN
  logic [NUM_SLOTS-1:0]          burnt_alarm;
  logic                          alarm_clr;
`endif

  // Driver side: debouncers / testbench.
  modport master (
`ifdef BBQ_BURN_ALARM_EN
    output alarm_clr,
    input  burnt_alarm,
`endif
    output tick,
    output flip,
    input  colour_fat,
    input  colour_muscle,
    input  level
  );

  // Controller side.
  modport slave (
`ifdef BBQ_BURN_ALARM_EN
    input  alarm_clr,
    output burnt_alarm,
`endif
    input  tick,
    input  flip,
    output colour_fat,
    output colour_muscle,
    output level
  );
endinterface

// File: rtl/bbq_steak_slot.sv
// One steak slot: doneness level, registered flip and tick counter, plus the
// colour lookup on the registered level. Burn alarm only with BBQ_BURN_ALARM_EN.
module bbq_steak_slot
  import bbq_pkg::*;
#(
  parameter int TICKS_PER_LEVEL = 3,
  parameter int COLOUR_W        = COLOUR_W_DEFAULT
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                tick,
  input  logic                flip,
`ifdef BBQ_BURN_ALARM_EN
  input  logic                alarm_clr,
  output logic                burnt_alarm,
`endif
  output logic [2:0]          level,
  output logic [COLOUR_W-1:0] colour_fat,
  output logic [COLOUR_W-1:0] colour_muscle
);
  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICKS_PER_LEVEL - 1);

  logic [2:0]       level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             held_q, held_d;
  logic             release_ev;
  logic             paused;
  logic             timer_adv;

  // Next-state: a release always wins over a tick and advances exactly once.
  always_comb begin
    level_d    = level_q;
    cnt_d      = cnt_q;
    held_d     = flip;
    timer_adv  = 1'b0;
    release_ev = held_q & ~flip;
    paused     = held_q | flip;
    if (release_ev) begin
      level_d = level_q + 3'd1;
      cnt_d   = '0;
    end else if (!paused && tick && (level_q != LVL_NONE)) begin
      if (cnt_q == CNT_LAST) begin
        level_d   = level_q + 3'd1;
        cnt_d     = '0;
        timer_adv = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Slot state registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      level_q <= LVL_NONE;
      cnt_q   <= '0;
      held_q  <= 1'b0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
      held_q  <= held_d;
    end
  end

`ifdef BBQ_BURN_ALARM_EN
  logic burnt_alarm_q, burnt_alarm_d;

  // Sticky alarm: set only when the timer pushes WELL into BURNT; clear wins.
  always_comb begin
    burnt_alarm_d = burnt_alarm_q | (timer_adv & (level_q == LVL_WELL));
    if (alarm_clr) burnt_alarm_d = 1'b0;
  end

  // Alarm register.
  always_ff @(posedge clk) begin
    if (!resetn) burnt_alarm_q <= 1'b0;
    else         burnt_alarm_q <= burnt_alarm_d;
  end

  assign burnt_alarm = burnt_alarm_q;
`endif

  assign level         = level_q;
  assign colour_fat    = COLOUR_W'(fat_colour(level_q));
  assign colour_muscle = COLOUR_W'(muscle_colour(level_q));

endmodule

// File: rtl/bbq_grill_controller.sv
// Barbeque Hero multi-slot doneness controller. Fans tick/alarm_clr out to one
// bbq_steak_slot per slot and packs the per-slot outputs onto the bus.
// Optional feature macro: BBQ_BURN_ALARM_EN (sticky per-slot burn alarm).
module bbq_grill_controller
  import bbq_pkg::*;
#(
  parameter int NUM_SLOTS       = 4,
  parameter int TICKS_PER_LEVEL = 3,
  parameter int COLOUR_W        = COLOUR_W_DEFAULT
) (
  input logic                   clk,
  input logic                   resetn,
  bbq_grill_controller_if.slave bus
);
  logic [NUM_SLOTS*3-1:0]        level_w;
  logic [NUM_SLOTS*COLOUR_W-1:0] fat_w;
  logic [NUM_SLOTS*COLOUR_W-1:0] muscle_w;
`ifdef BBQ_BURN_ALARM_EN
  logic [NUM_SLOTS-1:0]          alarm_w;
`endif

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    bbq_steak_slot #(
      .TICKS_PER_LEVEL(TICKS_PER_LEVEL),
      .COLOUR_W       (COLOUR_W)
    ) u_slot (
      .clk          (clk),
      .resetn       (resetn),
      .tick         (bus.tick),
      .flip         (bus.flip[g]),
`ifdef BBQ_BURN_ALARM_EN
      .alarm_clr    (bus.alarm_clr),
      .burnt_alarm  (alarm_w[g]),
`endif
      .level        (level_w[g*3 +: 3]),
      .colour_fat   (fat_w[g*COLOUR_W +: COLOUR_W]),
      .colour_muscle(muscle_w[g*COLOUR_W +: COLOUR_W])
    );
  end

  assign bus.level         = level_w;
  assign bus.colour_fat    = fat_w;
  assign bus.colour_muscle = muscle_w;
`ifdef BBQ_BURN_ALARM_EN
  assign bus.burnt_alarm   = alarm_w;
`endif

endmodule

// File: tb/tb_bbq_grill_controller.sv
// Self-checking bench for bbq_grill_controller (4 slots, 3 ticks per level).
module tb_bbq_grill_controller;
  localparam int NS  = 4;
  localparam int TPL = 3;
  localparam int CW  = 9;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  bbq_grill_controller_if #(.NUM_SLOTS(NS), .COLOUR_W(CW)) bus ();

  bbq_grill_controller #(.NUM_SLOTS(NS), .TICKS_PER_LEVEL(TPL), .COLOUR_W(CW)) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  // Expected colours per level, independent copy of the renderer palette.
  logic [CW-1:0] fat_tab [8] = '{9'h000, 9'h040, 9'h080, 9'h0C0, 9'h100, 9'h140, 9'h180, 9'h1C0};
  logic [CW-1:0] mus_tab [8] = '{9'h000, 9'h1E0, 9'h1A0, 9'h160, 9'h120, 9'h0E0, 9'h0A0, 9'h060};

  // Reference model state.
  int m_lvl [NS];
  int m_cnt [NS];
  bit m_held [NS];
  bit m_alarm [NS];

  int n_checks = 0;
  int n_fail   = 0;

  // One clock: drive inputs, update the model at the edge, return at the next negedge.
  task automatic step(input bit t, input logic [NS-1:0] f, input bit c, input bit rn);
    resetn   = rn;
    bus.tick = t;
    bus.flip = f;
`ifdef BBQ_BURN_ALARM_EN
    bus.alarm_clr = c;
`endif
    @(posedge clk);
    for (int i = 0; i < NS; i++) begin
      if (!rn) begin
        m_lvl[i] = 0; m_cnt[i] = 0; m_held[i] = 0; m_alarm[i] = 0;
      end else begin
        if (m_held[i] && !f[i]) begin
          m_lvl[i] = (m_lvl[i] + 1) % 8;
          m_cnt[i] = 0;
        end else if (!m_held[i] && !f[i] && t && m_lvl[i] != 0) begin
          m_cnt[i] = m_cnt[i] + 1;
          if (m_cnt[i] == TPL) begin
            m_lvl[i] = (m_lvl[i] + 1) % 8;
            m_cnt[i] = 0;
            if (m_lvl[i] == 7) m_alarm[i] = 1;
          end
        end
        if (c) m_alarm[i] = 0;
        m_held[i] = f[i];
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    step(0, '0, 0, 0);
    step(0, '0, 0, 0);
    n_checks++;
    if (bus.level !== '0) begin
      n_fail++; $display("FAIL reset_level got %h want 0", bus.level);
    end
    n_checks++;
    if (bus.colour_fat !== '0 || bus.colour_muscle !== '0) begin
      n_fail++; $display("FAIL reset_colour got %h/%h want 0/0", bus.colour_fat, bus.colour_muscle);
    end
`ifdef BBQ_BURN_ALARM_EN
    n_checks++;
    if (bus.burnt_alarm !== '0) begin
      n_fail++; $display("FAIL reset_alarm got %b want 0", bus.burnt_alarm);
    end
`endif
    step(0, '0, 0, 1);
  endtask

  task automatic test_place();
    step(0, 4'b0001, 0, 1);
    step(0, 4'b0001, 0, 1);
    n_checks++;
    if (bus.level[2:0] !== 3'd0) begin
      n_fail++; $display("FAIL place_held got %0d want 0", bus.level[2:0]);
    end
    step(0, 4'b0000, 0, 1);
    n_checks++;
    if (bus.level !== 12'h001) begin
      n_fail++; $display("FAIL place_release got %h want 001", bus.level);
    end
  endtask

  task automatic test_timer();
    int exp_lvl [6] = '{1, 1, 2, 2, 2, 3};
    for (int k = 0; k < 6; k++) begin
      step(1, '0, 0, 1);
      n_checks++;
      if (bus.level[2:0] !== exp_lvl[k][2:0]) begin
        n_fail++; $display("FAIL timer_tick%0d got %0d want %0d", k + 1, bus.level[2:0], exp_lvl[k]);
      end
      step(0, '0, 0, 1);
    end
  endtask

  task automatic test_release_tick();
    step(0, 4'b0010, 0, 1);
    step(0, 4'b0000, 0, 1);
    for (int k = 0; k < 5; k++) step(1, '0, 0, 1);
    n_checks++;
    if (bus.level[5:3] !== 3'd2) begin
      n_fail++; $display("FAIL rt_setup got %0d want 2", bus.level[5:3]);
    end
    step(0, 4'b0010, 0, 1);
    step(1, 4'b0000, 0, 1);
    n_checks++;
    if (bus.level[5:3] !== 3'd3) begin
      n_fail++; $display("FAIL rt_single_advance got %0d want 3", bus.level[5:3]);
    end
    step(1, '0, 0, 1);
    step(1, '0, 0, 1);
    n_checks++;
    if (bus.level[5:3] !== 3'd3) begin
      n_fail++; $display("FAIL rt_cnt_cleared got %0d want 3", bus.level[5:3]);
    end
    step(1, '0, 0, 1);
    n_checks++;
    if (bus.level[5:3] !== 3'd4) begin
      n_fail++; $display("FAIL rt_next_level got %0d want 4", bus.level[5:3]);
    end
  endtask

  task automatic test_pause();
    step(1, '0, 0, 1);
    step(0, 4'b0010, 0, 1);
    for (int k = 0; k < 5; k++) begin
      step(1, 4'b0010, 0, 1);
      n_checks++;
      if (bus.level[5:3] !== 3'd4) begin
        n_fail++; $display("FAIL pause_tick%0d got %0d want 4", k, bus.level[5:3]);
      end
    end
    step(0, 4'b0000, 0, 1);
    n_checks++;
    if (bus.level[5:3] !== 3'd5) begin
      n_fail++; $display("FAIL pause_release got %0d want 5", bus.level[5:3]);
    end
    step(1, '0, 0, 1);
    step(1, '0, 0, 1);
    step(1, '0, 0, 1);
    n_checks++;
    if (bus.level[5:3] !== 3'd6) begin
      n_fail++; $display("FAIL pause_after got %0d want 6", bus.level[5:3]);
    end
  endtask

  task automatic test_burn();
    int guard = 0;
    step(0, '0, 0, 0);
    step(0, 4'b0100, 0, 1);
    step(0, 4'b0000, 0, 1);
    while (m_lvl[2] != 7 && guard < 40) begin
      step(1, '0, 0, 1);
      guard++;
    end
    n_checks++;
    if (bus.level[8:6] !== 3'd7 || guard != 18) begin
      n_fail++; $display("FAIL burn_reach got %0d after %0d ticks want 7 after 18", bus.level[8:6], guard);
    end
`ifdef BBQ_BURN_ALARM_EN
    n_checks++;
    if (bus.burnt_alarm !== 4'b0100) begin
      n_fail++; $display("FAIL burn_alarm_set got %b want 0100", bus.burnt_alarm);
    end
`endif
    for (int k = 0; k < 3; k++) step(1, '0, 0, 1);
    n_checks++;
    if (bus.level[8:6] !== 3'd0) begin
      n_fail++; $display("FAIL burn_timeout got %0d want 0", bus.level[8:6]);
    end
`ifdef BBQ_BURN_ALARM_EN
    n_checks++;
    if (bus.burnt_alarm !== 4'b0100) begin
      n_fail++; $display("FAIL burn_alarm_sticky got %b want 0100", bus.burnt_alarm);
    end
    step(0, '0, 1, 1);
    n_checks++;
    if (bus.burnt_alarm !== 4'b0000) begin
      n_fail++; $display("FAIL burn_alarm_clr got %b want 0000", bus.burnt_alarm);
    end
`endif
    for (int k = 0; k < 7; k++) begin
      step(0, 4'b1000, 0, 1);
      step(0, 4'b0000, 0, 1);
    end
    n_checks++;
    if (bus.level[11:9] !== 3'd7) begin
      n_fail++; $display("FAIL release_burn got %0d want 7", bus.level[11:9]);
    end
`ifdef BBQ_BURN_ALARM_EN
    n_checks++;
    if (bus.burnt_alarm !== 4'b0000) begin
      n_fail++; $display("FAIL release_burn_alarm got %b want 0000", bus.burnt_alarm);
    end
`endif
    for (int k = 0; k < 10; k++) begin
      step(1, '0, 0, 1);
      n_checks++;
      if (bus.level[8:6] !== 3'd0) begin
        n_fail++; $display("FAIL none_hold%0d got %0d want 0", k, bus.level[8:6]);
      end
    end
  endtask

  task automatic test_all_release();
    step(0, '0, 0, 0);
    step(0, 4'b1111, 0, 1);
    step(0, 4'b0000, 0, 1);
    for (int i = 0; i < NS; i++) begin
      n_checks++;
      if (bus.level[i*3 +: 3] !== 3'd1 || bus.colour_fat[i*CW +: CW] !== 9'h040 ||
          bus.colour_muscle[i*CW +: CW] !== 9'h1E0) begin
        n_fail++;
        $display("FAIL all_raw slot%0d got lvl %0d fat %h mus %h want 1/040/1e0", i,
                 bus.level[i*3 +: 3], bus.colour_fat[i*CW +: CW], bus.colour_muscle[i*CW +: CW]);
      end
    end
    for (int k = 0; k < 4; k++) step(1, '0, 0, 1);
    step(1, 4'b1111, 0, 0);
    n_checks++;
    if (bus.level !== '0 || bus.colour_fat !== '0 || bus.colour_muscle !== '0) begin
      n_fail++; $display("FAIL midcook_reset got %h %h %h want 0", bus.level, bus.colour_fat, bus.colour_muscle);
    end
    step(0, '0, 0, 1);
  endtask

  task automatic test_random();
    logic [NS-1:0] f = '0;
    step(0, '0, 0, 0);
    for (int k = 0; k < 600; k++) begin
      bit t, c, rn;
      for (int i = 0; i < NS; i++) if ($urandom_range(0, 3) == 0) f[i] = ~f[i];
      t  = ($urandom_range(0, 2) == 0);
      c  = ($urandom_range(0, 19) == 0);
      rn = ($urandom_range(0, 249) != 0);
      step(t, f, c, rn);
      for (int i = 0; i < NS; i++) begin
        n_checks++;
        if (bus.level[i*3 +: 3] !== m_lvl[i][2:0] ||
            bus.colour_fat[i*CW +: CW] !== fat_tab[m_lvl[i]] ||
            bus.colour_muscle[i*CW +: CW] !== mus_tab[m_lvl[i]]) begin
          n_fail++;
          $display("FAIL rand_c%0d_s%0d got lvl %0d fat %h mus %h want lvl %0d fat %h mus %h", k, i,
                   bus.level[i*3 +: 3], bus.colour_fat[i*CW +: CW], bus.colour_muscle[i*CW +: CW],
                   m_lvl[i], fat_tab[m_lvl[i]], mus_tab[m_lvl[i]]);
        end
`ifdef BBQ_BURN_ALARM_EN
        n_checks++;
        if (bus.burnt_alarm[i] !== m_alarm[i]) begin
          n_fail++; $display("FAIL rand_alarm_c%0d_s%0d got %b want %b", k, i, bus.burnt_alarm[i], m_alarm[i]);
        end
`endif
      end
    end
  endtask

  initial begin
    bus.tick = 1'b0;
    bus.flip = '0;
`ifdef BBQ_BURN_ALARM_EN
    bus.alarm_clr = 1'b0;
`endif
    @(negedge clk);
    test_reset();
    test_place();
    test_timer();
    test_release_tick();
    test_pause();
    test_burn();
    test_all_release();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
